// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the vending machine change path.
package vm_pkg;

    localparam int DEFAULT_AMT_W = 4;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FARTH = 2'd1,
        HALF  = 2'd2,
        PENNY = 2'd3
    } coin_t;

    localparam logic [2:0] DENOM_FARTH = 3'd1;
    localparam logic [2:0] DENOM_HALF  = 3'd2;
    localparam logic [2:0] DENOM_PENNY = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SELECT     = 3'd1,
        EJECT      = 3'd2,
        WAIT_SENSE = 3'd3,
        DONE       = 3'd4,
        FAULT      = 3'd5
    } disp_state_t;

    // Value in farthings of a hopper coin.
    function automatic logic [2:0] coin_value(input coin_t c);
        logic [2:0] v;
        case (c)
            PENNY:   v = DENOM_PENNY;
            HALF:    v = DENOM_HALF;
            FARTH:   v = DENOM_FARTH;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_eject_timer.sv
// Loadable down-counter shared by the solenoid pulse and the sense timeout.
// tc is high on the last enabled cycle of a loaded interval.
module eject_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins over counting, holds at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = en && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays the owed amount coin by coin, largest
// denomination first, confirming each coin on the drop sensor.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2_500_000,
    parameter int SENSE_TIMEOUT = 25_000_000,
    parameter int AMT_W         = DEFAULT_AMT_W
) (
    input  logic             clk50m,
    input  logic             res,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             coin_sense,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic             eject_penny,
    output logic             eject_half,
    output logic             eject_farth
);

    localparam int MAX_CNT = (PULSE_CYCLES > SENSE_TIMEOUT) ? PULSE_CYCLES : SENSE_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    // Timer runs load+1 cycles, so load one less than the interval.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_TIMEOUT - 1);

    disp_state_t      state_r, state_nx_s;
    coin_t            coin_r, coin_nx_s;
    logic [AMT_W-1:0] remaining_r, remaining_nx_s;
    logic [AMT_W-1:0] denom_s;
    logic             busy_r, done_r, fault_r;
    logic             seen_r, seen_nx_s;
    logic             sense_d_r, rise_s;
    logic             tmr_load_s, tmr_en_s, tmr_tc_s;
    logic [CNT_W-1:0] tmr_val_s;

    assign rise_s  = coin_sense & ~sense_d_r;
    assign denom_s = AMT_W'(coin_value(coin_r));

    eject_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk50m),
        .rst      (res),
        .load     (tmr_load_s),
        .en       (tmr_en_s),
        .load_val (tmr_val_s),
        .tc       (tmr_tc_s)
    );

    // Next-state, coin selection, payout arithmetic and timer control.
    always_comb begin
        state_nx_s     = state_r;
        coin_nx_s      = coin_r;
        remaining_nx_s = remaining_r;
        seen_nx_s      = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_en_s       = 1'b0;
        tmr_val_s      = PULSE_LOAD;
        case (state_r)
            IDLE, FAULT: begin
                if (req) begin
                    remaining_nx_s = amount;
                    if (amount != {AMT_W{1'b0}}) begin
                        state_nx_s = SELECT;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            SELECT: begin
                if (remaining_r >= AMT_W'(DENOM_PENNY)) begin
                    coin_nx_s = PENNY;
                end else if (remaining_r >= AMT_W'(DENOM_HALF)) begin
                    coin_nx_s = HALF;
                end else if (remaining_r == AMT_W'(DENOM_FARTH)) begin
                    coin_nx_s = FARTH;
                end else begin
                    coin_nx_s = NONE;
                end
                if (coin_nx_s != NONE) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PULSE_LOAD;
                    state_nx_s = EJECT;
                end else begin
                    state_nx_s = DONE;
                end
            end
            EJECT: begin
                tmr_en_s  = 1'b1;
                seen_nx_s = seen_r | rise_s;
                if (tmr_tc_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SENSE_LOAD;
                    state_nx_s = WAIT_SENSE;
                end else begin
                    state_nx_s = EJECT;
                end
            end
            WAIT_SENSE: begin
                tmr_en_s = 1'b1;
                if (seen_r) begin
                    remaining_nx_s = remaining_r - denom_s;
                    state_nx_s     = SELECT;
                end else if (tmr_tc_s) begin
                    state_nx_s = FAULT;
                end else begin
                    seen_nx_s  = rise_s;
                    state_nx_s = WAIT_SENSE;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk50m or posedge res) begin
        if (res) begin
            state_r     <= IDLE;
            coin_r      <= NONE;
            remaining_r <= {AMT_W{1'b0}};
            seen_r      <= 1'b0;
            sense_d_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            coin_r      <= coin_nx_s;
            remaining_r <= remaining_nx_s;
            seen_r      <= seen_nx_s;
            sense_d_r   <= coin_sense;
            busy_r      <= (state_nx_s inside {SELECT, EJECT, WAIT_SENSE});
            done_r      <= (state_nx_s == DONE);
            fault_r     <= (state_nx_s == FAULT);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign fault       = fault_r;
    assign remaining   = remaining_r;
    // Decoded from registers only; a single coin code keeps the lines exclusive.
    assign eject_penny = (state_r == EJECT) && (coin_r == PENNY);
    assign eject_half  = (state_r == EJECT) && (coin_r == HALF);
    assign eject_farth = (state_r == EJECT) && (coin_r == FARTH);

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout controller for the vending machine's change path: accepts a change amount in farthings from the main vending state machine over a req/busy handshake and drives the penny, halfpenny and farthing hopper solenoids one coin at a time, largest denomination first. Each ejection is confirmed by the coin-drop sensor; a missing confirmation raises a fault. Sits between the vending state machine (change-owed side) and the physical hopper, and feeds the change seven-segment display through `remaining`.

## Interface
- `PULSE_CYCLES`, 2_500_000, solenoid pulse width in `clk50m` cycles (50 ms); minimum 1.
- `SENSE_TIMEOUT`, 25_000_000, cycles allowed after pulse end for the coin-drop edge (0.5 s); minimum 1.
- `AMT_W`, 4, width of change amount in farthings.

Ports:
- `clk50m`  in  1  system clock; the single clock.
- `res`  in  1  reset, asynchronous, active-high.
- `req`  in  1  change request; sampled only in IDLE or FAULT.
- `amount`  in  AMT_W  change owed in farthings, valid with `req`.
- `coin_sense`  in  1  coin-drop sensor, synchronous to `clk50m`; rising edge means one coin dropped.
- `busy`  out  1  high from acceptance until DONE/FAULT.
- `done`  out  1  one-cycle pulse when payout completes.
- `fault`  out  1  sticky; set on sense timeout.
- `remaining`  out  AMT_W  farthings still owed.
- `eject_penny`, `eject_half`, `eject_farth`  out  1 each  solenoid drives; at most one high at any time.

## Operation
- Denominations: penny = 4, halfpenny = 2, farthing = 1.
- States: IDLE, SELECT, EJECT, WAIT_SENSE, DONE, FAULT.
- IDLE: `req` with `amount != 0` -> latch `remaining = amount`, `busy = 1`, go to SELECT. `req` with `amount == 0` -> go to DONE. No `req` -> stay.
- SELECT: `remaining >= 4` -> penny; `>= 2` -> halfpenny; `== 1` -> farthing; `== 0` -> DONE. Load the pulse counter and go to EJECT.
- EJECT: the selected eject line is high for exactly `PULSE_CYCLES` cycles, then go to WAIT_SENSE and load the timeout counter.
- A `coin_sense` rising edge during EJECT or WAIT_SENSE sets `seen`. Extra edges in the same coin are ignored. Edges in any other state are ignored.
- WAIT_SENSE: if `seen` is set (checked on entry or any later cycle), subtract the denomination from `remaining`, clear `seen`, and go to SELECT. Otherwise, once `SENSE_TIMEOUT` cycles elapse, go to FAULT.
- DONE: `done = 1` for one cycle and `busy = 0`, then go to IDLE.
- FAULT: `fault = 1`, `busy = 0`, all ejects low, and `remaining` holds the unpaid amount. `req` is accepted exactly as in IDLE and clears `fault`.
- `req` while busy is ignored; there is no queueing.
- Subtraction never underflows, because the selection rule guarantees the denomination is no greater than `remaining`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `fault` and all ejects 0; `remaining` 0; counters and `seen` cleared.
- `res` mid-operation: the eject line drops immediately (asynchronously) and the coin in flight is abandoned.
- Acceptance latency:
  - `req` sampled at edge N -> `busy` and `remaining` valid after N.
  - Eject line rises after edge N+1 (the SELECT cycle).
- Coin cycle with a prompt sense: 1 (SELECT) + `PULSE_CYCLES` + 1 (WAIT_SENSE) cycles per coin.
- `remaining` updates on the edge leaving WAIT_SENSE.
- `done` rises one cycle after the SELECT that sees 0. For `amount == 0`, `done` rises the cycle after `req` is sampled.
- Timeout: FAULT is entered `SENSE_TIMEOUT` cycles after the last EJECT cycle.
- All outputs are registered; ejects are decoded from registered state plus the registered coin select.

## Structure
- Package `vm_pkg`:
  - `coin_t` enum (NONE, FARTH, HALF, PENNY);
  - denomination constants 1/2/4;
  - `disp_state_t` state enum;
  - `AMT_W` default.
- Sub-module `eject_timer`: a loadable down-counter with a terminal-count pulse, instantiated once and shared by the EJECT and WAIT_SENSE phases (reloaded per phase).
- Rising-edge detection on `coin_sense` stays inline (one flop).

## Test plan
Bench parameters: `PULSE_CYCLES = 4`, `SENSE_TIMEOUT = 8`. Sense model pulses `coin_sense` 2 cycles after each eject rise.
- `amount = 7`:
  - ejects penny, half, farth in that order, each exactly 4 cycles high;
  - `remaining` steps 7 -> 3 -> 1 -> 0;
  - one `done` pulse, `busy` low afterwards.
- `amount = 15` -> ejects penny, penny, penny, half, farth, then `done`; never two ejects high together.
- `amount = 0` -> `done` high the cycle after `req` is sampled, no eject, `busy` stays 0.
- `amount = 6`, sense model disabled:
  - `eject_penny` high 4 cycles, then FAULT 8 cycles later;
  - `fault = 1`, `remaining = 6`, `busy = 0`;
  - new `req` with `amount = 2` clears `fault` and pays one halfpenny.
- `amount = 5` with a second `req` (`amount = 3`) during EJECT -> second request ignored; payout is penny + farth only.
- `res` asserted mid-pulse of `eject_penny` -> eject and `busy` drop without waiting for a clock edge; `remaining = 0`; IDLE after release.
